dm_access_ctrl: RTL and testbench

- Load/store access controller between the datapath (ALU address, rt store data) and the 4 KB word-organised data memory (1024 x 32, 10-bit word address, combinational read, write on posedge clk).
- Supports word, halfword and byte loads and stores, with sign or zero extension on loads.
- Sub-word stores are performed as a read-modify-write on the full memory word.
- Runs a 3-state FSM, raises busy for the control unit to stall on, and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/dm_access_ctrl_if.sv | 34 +++
 rtl/dm_access_ctrl.sv | 139 +++++++++++++
 tb/tb_dm_access_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_if.sv
// Load/store bus between the datapath/control side and the access
// controller, plus the controller's port onto the word-organised data memory.
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 10
);
    // Requester side
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              fault;
    logic [31:0]       rdata;
    // Data memory side
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_we;
    logic [31:0]       dm_dout;

    // Controller view
    modport slave (
        input  req, we, size, sext, addr, wdata, dm_dout,
        output busy, done, fault, rdata, dm_addr, dm_din, dm_we
    );

    // Requester + memory view (the environment around the controller)
    modport master (
        output req, we, size, sext, addr, wdata, dm_dout,
        input  busy, done, fault, rdata, dm_addr, dm_din, dm_we
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store access controller: byte/half/word loads with sign or zero
// extension, sub-word stores via read-modify-write on the full memory word,
// alignment and range faulting without touching memory.
module dm_access_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int RANGE_CHK = 1
) (
    input  logic              clk,
    input  logic              rst,
    dm_access_ctrl_if.slave   bus
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic              fault_q;
    logic              busy_q;
    logic              done_q;
    logic [31:0]       rdata_q;

    logic              misalign_d;
    logic              range_err_d;
    logic [31:0]       load_d;
    logic [31:0]       merge_d;
    logic [31:0]       lane_shift;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic              dm_we_d;

    // Alignment and range check on the incoming (not yet latched) request
    always_comb begin
        misalign_d = 1'b0;
        case (bus.size)
            SZ_BYTE: misalign_d = 1'b0;
            SZ_HALF: misalign_d = bus.addr[0];
            default: misalign_d = |bus.addr[1:0];
        endcase
        range_err_d = (RANGE_CHK != 0) && ((bus.addr >> (ADDR_W + 2)) != 32'd0);
    end

    // Lane selection and extension of the memory word for loads
    always_comb begin
        lane_shift = bus.dm_dout >> {addr_q[1:0], 3'b000};
        byte_v     = lane_shift[7:0];
        half_v     = addr_q[1] ? bus.dm_dout[31:16] : bus.dm_dout[15:0];
        case (size_q)
            SZ_BYTE: load_d = {{24{sext_q & byte_v[7]}}, byte_v};
            SZ_HALF: load_d = {{16{sext_q & half_v[15]}}, half_v};
            default: load_d = bus.dm_dout;
        endcase
    end

    // Store merge: replace only the addressed lane(s) of the current word
    always_comb begin
        merge_d = bus.dm_dout;
        case (size_q)
            SZ_BYTE: merge_d[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            SZ_HALF: merge_d[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merge_d = wdata_q;
        endcase
    end

    // Write strobe decoded from state so an async reset kills it immediately
    assign dm_we_d     = (state_q == S_ACCESS) && we_q;

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.fault   = done_q & fault_q;
    assign bus.rdata   = rdata_q;
    assign bus.dm_addr = addr_q[ADDR_W+1:2];
    assign bus.dm_we   = dm_we_d;
    assign bus.dm_din  = dm_we_d ? merge_d : 32'd0;

    // Access FSM with registered busy/done/rdata
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.req) begin
                        addr_q  <= bus.addr[ADDR_W+1:0];
                        wdata_q <= bus.wdata;
                        we_q    <= bus.we;
                        size_q  <= bus.size;
                        sext_q  <= bus.sext;
                        busy_q  <= 1'b1;
                        if (misalign_d || range_err_d) begin
                            // Faulted: skip memory entirely
                            fault_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            fault_q <= 1'b0;
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    // Memory commits the store on this same edge
                    if (!we_q) rdata_q <= load_d;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed scenarios followed by random accesses,
// all checked against an arithmetic model of memory contents and rdata.
module tb_dm_access_ctrl;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dm_access_ctrl_if #(.ADDR_W(AW)) bus();

    dm_access_ctrl #(.ADDR_W(AW), .RANGE_CHK(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on posedge
    logic [31:0] mem [1024] = '{default: 32'd0};
    always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr] <= bus.dm_din;
    assign bus.dm_dout = mem[bus.dm_addr];

    // Reference model state
    logic [31:0] ref_mem [1024] = '{default: 32'd0};
    logic [31:0] ref_rdata = 32'd0;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access, with model update and timing/result checks
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd);
        logic        flt;
        logic [9:0]  wi;
        int          bi, lat, nwe, exp_lat;
        logic [31:0] mask, v, nw;
        logic        seen;
        wi   = a[11:2];
        bi   = int'(a[1:0]);
        flt  = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0) || (a >= 32'h1000);
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        nw   = ref_mem[wi];
        if (!flt && w)
            nw = (ref_mem[wi] & ~(mask << (8 * bi))) | ((wd & mask) << (8 * bi));
        if (!flt && !w) begin
            v = (ref_mem[wi] >> (8 * bi)) & mask;
            if (sx && (v & ((mask >> 1) + 32'd1)) != 32'd0) v = v | ~mask;
            ref_rdata = v;
        end
        exp_lat = flt ? 1 : 2;

        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sext = sx;
        bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("busy_accept", 32'(bus.busy), 32'd1);
        lat = 0; nwe = 0; seen = 1'b0;
        for (int c = 1; c <= 5 && !seen; c++) begin
            @(negedge clk);
            if (bus.dm_we) begin
                nwe++;
                check("dm_addr", 32'(bus.dm_addr), 32'(wi));
                check("dm_din", bus.dm_din, nw);
            end
            if (bus.done) begin
                seen = 1'b1;
                lat  = c;
                check("fault", 32'(bus.fault), 32'(flt));
            end
        end
        check("done_latency", 32'(lat), 32'(exp_lat));
        check("dm_we_count", 32'(nwe), (w && !flt) ? 32'd1 : 32'd0);
        if (!flt && w) ref_mem[wi] = nw;
        @(negedge clk);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("done_low", 32'(bus.done), 32'd0);
        check("rdata", bus.rdata, ref_rdata);
        check("mem_word", mem[wi], ref_mem[wi]);
    endtask

    logic [31:0] cur, old, ra;
    int ndone;

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.sext = 1'b0;
        bus.addr = 32'd0; bus.wdata = 32'd0;

        // Reset values
        #12;
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_fault",   32'(bus.fault),   32'd0);
        check("rst_dm_we",   32'(bus.dm_we),   32'd0);
        check("rst_rdata",   bus.rdata,        32'd0);
        check("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
        check("rst_dm_din",  bus.dm_din,       32'd0);
        @(negedge clk); rst = 1'b0;

        // Word store then load
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        check("word_load", bus.rdata, 32'hDEADBEEF);

        // Byte read-modify-write
        access(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
        access(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
        check("byte_rmw", mem[8], 32'h1122AA44);

        // Sign/zero extension
        access(1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF7F01);
        access(1'b0, 2'd0, 1'b1, 32'h32, 32'd0);
        check("lb", bus.rdata, 32'hFFFFFFFF);
        access(1'b0, 2'd0, 1'b0, 32'h33, 32'd0);
        check("lbu", bus.rdata, 32'h00000080);
        access(1'b0, 2'd1, 1'b1, 32'h32, 32'd0);
        check("lh", bus.rdata, 32'hFFFF80FF);
        access(1'b0, 2'd1, 1'b0, 32'h30, 32'd0);
        check("lhu", bus.rdata, 32'h00007F01);

        // Faults: rdata must stay at the last good load
        access(1'b0, 2'd2, 1'b0, 32'h6,    32'd0);
        access(1'b1, 2'd1, 1'b0, 32'h3,    32'h5555);
        access(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0);
        check("fault_rdata_kept", bus.rdata, 32'h00007F01);

        // size 11 behaves as word
        access(1'b1, 2'd3, 1'b0, 32'h44, 32'hCAFEF00D);
        access(1'b0, 2'd3, 1'b1, 32'h44, 32'd0);

        // Held request: one accept every 3 cycles
        @(negedge clk);
        cur = 32'h10;
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.sext = 1'b0; bus.addr = cur;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("busy_pattern", 32'(bus.busy), (i % 3 == 2) ? 32'd0 : 32'd1);
            if (bus.done) ndone++;
            if (i % 3 == 2) begin
                if (i == 11) bus.req = 1'b0;
                else begin
                    cur = (cur == 32'h10) ? 32'h14 : 32'h10;
                    bus.addr = cur;
                end
            end
        end
        check("held_req_dones", 32'(ndone), 32'd4);
        ref_rdata = ref_mem[cur[11:2]];
        @(negedge clk);
        check("held_req_rdata", bus.rdata, ref_rdata);

        // Async reset during the ACCESS cycle of a store
        access(1'b1, 2'd2, 1'b0, 32'h40, 32'h5A5A1234);
        old = ref_mem[16];
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = 32'h40;
        bus.wdata = $urandom;
        @(posedge clk); #2;
        bus.req = 1'b0;
        check("we_before_rst", 32'(bus.dm_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_dm_we",   32'(bus.dm_we),   32'd0);
        check("rst_mid_busy",    32'(bus.busy),    32'd0);
        check("rst_mid_done",    32'(bus.done),    32'd0);
        check("rst_mid_rdata",   bus.rdata,        32'd0);
        check("rst_mid_dm_addr", 32'(bus.dm_addr), 32'd0);
        check("rst_mid_dm_din",  bus.dm_din,       32'd0);
        ref_rdata = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        check("rst_no_done", 32'(ndone), 32'd0);
        check("rst_mem_kept", mem[16], old);

        // Random accesses, occasionally out of range
        for (int k = 0; k < 80; k++) begin
            ra = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) ra = ra | (32'($urandom_range(1, 255)) << 12);
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ra, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
